// File: rtl/alu_pkg.sv
// Shared definitions for the picoMIPS ALU and its write-back stage.
// Function codes, flag bit positions and branch condition codes.
package alu_pkg;

  typedef enum logic [2:0] {
    RA   = 3'd0,
    RB   = 3'd1,
    RADD = 3'd2,
    RSUB = 3'd3,
    RAND = 3'd4,
    ROR  = 3'd5,
    RXOR = 3'd6,
    RNOR = 3'd7
  } alu_fn_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    BR_NEVER  = 3'd0,
    BR_ALWAYS = 3'd1,
    BR_EQ     = 3'd2,
    BR_NE     = 3'd3,
    BR_LT     = 3'd4,
    BR_GE     = 3'd5,
    BR_CS     = 3'd6,
    BR_CC     = 3'd7
  } br_cond_t;

endpackage

// File: rtl/wb_cond_eval.sv
// Branch condition evaluator over a {V,N,Z,C} flag vector.
// Purely combinational; shared with the branch unit.
module wb_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic lt;
  assign lt = flags[FLAG_N] ^ flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    unique case (br_cond_t'(br_cond))
      BR_NEVER:  taken = 1'b0;
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = flags[FLAG_Z];
      BR_NE:     taken = !flags[FLAG_Z];
      BR_LT:     taken = lt;
      BR_GE:     taken = !lt;
      BR_CS:     taken = flags[FLAG_C];
      BR_CC:     taken = !flags[FLAG_C];
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// One-entry write-back register behind the ALU with operand
// forwarding, architectural flags and retired-op counter.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int n  = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [n-1:0]  ex_result,
  input  logic [3:0]    ex_flags,
  input  logic          ex_wr_en,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic          ex_flags_en,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic          wb_wr_en,
  output logic [AW-1:0] wb_addr,
  output logic [n-1:0]  wb_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [n-1:0]  rs_data,
  input  logic [n-1:0]  rt_data,
  output logic [n-1:0]  op_a,
  output logic [n-1:0]  op_b,
  input  logic [2:0]    br_cond,
  output logic          br_taken,
  output logic [3:0]    flags_q,
  output logic [CW-1:0] retired
);

  logic          valid_q, valid_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  data_q, data_d;
  logic [3:0]    flg_q, flg_d;
  logic [CW-1:0] ret_q, ret_d;
  logic          accept, retire;
  logic          fwd_ok;

  assign ex_ready = !valid_q || wb_ready;
  assign accept   = ex_valid && ex_ready;
  assign retire   = valid_q && wb_ready;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    flg_d   = flg_q;
    ret_d   = ret_q;
    if (accept) begin
      valid_d = 1'b1;
      we_d    = ex_wr_en;
      addr_d  = ex_wr_addr;
      data_d  = ex_result;
    end else if (retire) begin
      valid_d = 1'b0;
    end
    // Flags commit at accept so the next branch sees them.
    if (accept && ex_flags_en) flg_d = ex_flags;
    if (retire) ret_d = ret_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      flg_q   <= '0;
      ret_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      flg_q   <= flg_d;
      ret_q   <= ret_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign wb_wr_en = valid_q && we_q && (addr_q != '0);
  assign flags_q  = flg_q;
  assign retired  = ret_q;

  // r0 is hard-wired zero, so it is never a forwarding source.
  assign fwd_ok = valid_q && we_q && (addr_q != '0);
  assign op_a = (fwd_ok && addr_q == rs_addr) ? data_q : rs_data;
  assign op_b = (fwd_ok && addr_q == rt_addr) ? data_q : rt_data;

  wb_cond_eval u_cond (
    .br_cond (br_cond),
    .flags   (flg_q),
    .taken   (br_taken)
  );

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed ops, stall,
// forwarding, flags/branch and counter wrap (CW=4).
module tb_alu_wb_stage;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [N-1:0]  ex_result = '0;
  logic [3:0]    ex_flags = '0;
  logic          ex_wr_en = 1'b0;
  logic [AW-1:0] ex_wr_addr = '0;
  logic          ex_flags_en = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic          wb_wr_en;
  logic [AW-1:0] wb_addr;
  logic [N-1:0]  wb_data;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [N-1:0]  rs_data = '0;
  logic [N-1:0]  rt_data = '0;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [2:0]    br_cond = '0;
  logic          br_taken;
  logic [3:0]    flags_q;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
    logic          strobe;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_wb_stage #(.n(N), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_flags(ex_flags),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_flags_en(ex_flags_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .op_a(op_a), .op_b(op_b),
    .br_cond(br_cond), .br_taken(br_taken),
    .flags_q(flags_q), .retired(retired)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: an entry retires at the next edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", {24'h0, wb_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e.addr));
        chk("wb_data", 32'(wb_data), 32'(e.data));
        chk("wb_wr_en", 32'(wb_wr_en), 32'(e.strobe));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a,
                      input logic we, input logic [3:0] f,
                      input logic fe);
    int k;
    exp_t e;
    k = 0;
    ex_valid = 1'b1;
    ex_result = d;
    ex_wr_addr = a;
    ex_wr_en = we;
    ex_flags = f;
    ex_flags_en = fe;
    @(negedge clk);
    while (!ex_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ex_ready) begin
      chk("send_timeout", 32'(ex_ready), 32'd1);
    end else begin
      e.addr = a;
      e.data = d;
      e.strobe = we && (a != 3'd0);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_wr_en = 1'b0;
    ex_flags_en = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    q.delete();
    repeat (cyc) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with ex_valid held high
    ex_valid = 1'b1;
    ex_result = 8'hEE;
    ex_wr_en = 1'b1;
    ex_wr_addr = 3'd5;
    ex_flags = 4'hF;
    ex_flags_en = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single write
    wb_ready = 1'b1;
    send(8'h5A, 3'd3, 1'b1, 4'b0000, 1'b1);
    idle();
    @(negedge clk);
    chk("single_strobe", 32'(wb_wr_en), 32'd1);
    chk("single_addr", 32'(wb_addr), 32'd3);
    chk("single_data", 32'(wb_data), 32'h5A);
    @(posedge clk);
    @(negedge clk);
    chk("single_retired", 32'(retired), 32'd1);

    // Back-to-back with a 3-cycle stall
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    send(8'h11, 3'd1, 1'b1, 4'b0000, 1'b0);
    fork
      send(8'h22, 3'd2, 1'b1, 4'b0000, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_ex_ready", 32'(ex_ready), 32'd0);
          chk("stall_hold", 32'(wb_data), 32'h11);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
      end
    join
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("stall_retired", 32'(retired), 32'd3);

    // Forwarding from a pending write to r4
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    send(8'h7F, 3'd4, 1'b1, 4'b0000, 1'b0);
    idle();
    rs_addr = 3'd4;
    rs_data = 8'h00;
    rt_addr = 3'd5;
    rt_data = 8'h44;
    @(negedge clk);
    chk("fwd_op_a", 32'(op_a), 32'h7F);
    chk("nofwd_op_b", 32'(op_b), 32'h44);
    rt_addr = 3'd4;
    #1;
    chk("fwd_op_b", 32'(op_b), 32'h7F);
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;

    // A pending write to r0 is neither forwarded nor strobed
    wb_ready = 1'b0;
    send(8'h99, 3'd0, 1'b1, 4'b0000, 1'b0);
    idle();
    rs_addr = 3'd0;
    rs_data = 8'h12;
    rt_addr = 3'd0;
    rt_data = 8'h33;
    @(negedge clk);
    chk("r0_op_a", 32'(op_a), 32'h12);
    chk("r0_op_b", 32'(op_b), 32'h33);
    chk("r0_strobe", 32'(wb_wr_en), 32'd0);
    chk("r0_valid", 32'(wb_valid), 32'd1);
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fwd_retired", 32'(retired), 32'd5);

    // Flags from a SUB: V=1 N=0 Z=0 C=1
    @(posedge clk);
    #1;
    send(8'h10, 3'd5, 1'b1, 4'b1001, 1'b1);
    idle();
    br_cond = 3'd4;
    @(negedge clk);
    chk("flags_sub", 32'(flags_q), 32'b1001);
    chk("br_lt", 32'(br_taken), 32'd1);
    br_cond = 3'd5; #1;
    chk("br_ge", 32'(br_taken), 32'd0);
    br_cond = 3'd6; #1;
    chk("br_cs", 32'(br_taken), 32'd1);
    br_cond = 3'd7; #1;
    chk("br_cc", 32'(br_taken), 32'd0);
    br_cond = 3'd2; #1;
    chk("br_eq", 32'(br_taken), 32'd0);
    br_cond = 3'd3; #1;
    chk("br_ne", 32'(br_taken), 32'd1);
    br_cond = 3'd0; #1;
    chk("br_never", 32'(br_taken), 32'd0);
    br_cond = 3'd1; #1;
    chk("br_always", 32'(br_taken), 32'd1);
    @(posedge clk);
    #1;
    send(8'h00, 3'd6, 1'b1, 4'b0110, 1'b0);
    idle();
    @(negedge clk);
    chk("flags_hold", 32'(flags_q), 32'b1001);
    @(posedge clk);
    #1;
    send(8'h00, 3'd6, 1'b1, 4'b0110, 1'b1);
    idle();
    br_cond = 3'd2;
    @(negedge clk);
    chk("flags_load", 32'(flags_q), 32'b0110);
    chk("br_eq_set", 32'(br_taken), 32'd1);
    br_cond = 3'd4; #1;
    chk("br_lt_n", 32'(br_taken), 32'd1);
    br_cond = 3'd6; #1;
    chk("br_cs_clr", 32'(br_taken), 32'd0);

    // Reset while an entry is stalled discards it
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    send(8'hAB, 3'd3, 1'b1, 4'b1111, 1'b1);
    idle();
    do_reset(1);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_strobe", 32'(wb_wr_en), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_flags", 32'(flags_q), 32'd0);

    // Counter wrap at CW=4 with a back-to-back burst
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++)
      send(8'(i + 8'h40), 3'd7, 1'(i % 2), 4'b0000, 1'b0);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("wrap_15", 32'(retired), 32'd15);
    @(posedge clk);
    #1;
    send(8'hC3, 3'd7, 1'b1, 4'b0000, 1'b0);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("wrap_0", 32'(retired), 32'd0);
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Pipeline stage directly downstream of the picoMIPS 8-bit ALU.
- Registers the ALU result and its V,N,Z,C flags into a one-entry write-back register, then drives the register-file write port.
- Keeps the architectural flags register used for branch evaluation.
- Forwards the pending write-back value to the ALU operand inputs, resolving read-after-write hazards without stalling.

Parameters:
- n, 8, datapath width; must match the ALU width.
- AW, 3, register address width (2**AW registers; register 0 reads as zero).
- CW, 16, width of the retired-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  ALU stage presents a valid operation this cycle.
- ex_ready  out  1  stage accepts the operation this cycle.
- ex_result  in  n  ALU result.
- ex_flags  in  4  ALU flags {V,N,Z,C}.
- ex_wr_en  in  1  operation writes a register.
- ex_wr_addr  in  AW  destination register.
- ex_flags_en  in  1  operation updates the flags register.
- wb_valid  out  1  write-back register holds an entry.
- wb_ready  in  1  register-file write port accepts the entry.
- wb_wr_en  out  1  write strobe; equals wb_valid & stored wr_en & (stored addr != 0).
- wb_addr  out  AW  write address.
- wb_data  out  n  write data.
- rs_addr, rt_addr  in  AW each  source addresses of the instruction in the ALU stage.
- rs_data, rt_data  in  n each  register-file read data.
- op_a, op_b  out  n each  forwarded operands to ALU a/b.
- br_cond  in  3  branch condition code.
- br_taken  out  1  condition evaluated on flags_q.
- flags_q  out  4  architectural flags {V,N,Z,C}.
- retired  out  CW  count of entries handed to the register file.

Behaviour:
- Reset (synchronous, active-high):
  - wb_valid=0; stored entry cleared; flags_q=0; retired=0.
  - Reset mid-transfer discards the pending entry; no write strobe is issued in the reset cycle's successor.
- Handshake:
  - ex_ready = !wb_valid | wb_ready (combinational; registered in no path).
  - Accept = ex_valid & ex_ready; on accept, result/addr/wr_en are loaded in the same edge.
  - Retire = wb_valid & wb_ready.
- Next-state of wb_valid:
  - Accept → 1.
  - Retire without accept → 0.
  - Otherwise → hold.
- Simultaneous retire and accept: the old entry leaves and the new entry loads on the same edge. Throughput is 1 per cycle; latency from ALU to write port is 1 cycle.
- Holding: while wb_valid & !wb_ready, the entry and all wb_* outputs are held stable; ex_ready=0.
- Flags:
  - flags_q <= ex_flags on accept & ex_flags_en; otherwise hold.
  - Flags commit at accept, not at retire, so a following branch sees them 1 cycle after the ALU op.
- Forwarding (combinational):
  - op_a = wb_data if wb_valid & stored wr_en & stored addr == rs_addr & rs_addr != 0; else rs_data.
  - op_b uses the same rule with rt_addr and rt_data.
  - Address 0 is never forwarded.
- Branch codes, evaluated on flags_q:
  - 0 NEVER → 0
  - 1 ALWAYS → 1
  - 2 EQ → Z
  - 3 NE → !Z
  - 4 LT → N^V
  - 5 GE → !(N^V)
  - 6 CS → C
  - 7 CC → !C
- retired: increments on each retire, including entries with wr_en=0. Wraps 2**CW-1 → 0 with no flag.
- No latches; all outputs are defined every cycle.

Decomposition:
- Shared package alu_pkg holds:
  - ALU func codes (replacing the macro include), kept as the single source for the ALU and this stage.
  - Flag bit indices: V=3, N=2, Z=1, C=0.
  - Branch condition enum (3-bit).
- One sub-module: wb_cond_eval (combinational; inputs br_cond and flags, output taken). It is reused later by the branch unit.

Test Plan:
- Reset flow: assert reset 2 cycles while ex_valid=1 → wb_valid=0, flags_q=0, retired=0, ex_ready=1 after release.
- Single write: ex_result=8'h5A, addr=3, wr_en=1, flags=4'b0000, wb_ready=1 → the next cycle shows wb_wr_en=1, wb_addr=3, wb_data=5A; retired=1 one cycle later.
- Back-to-back with stall: ops 8'h11→r1 then 8'h22→r2, wb_ready=0 for 3 cycles:
  - ex_ready=0 during the stall.
  - wb_data holds 11.
  - Once wb_ready=1, 11 then 22 appear on consecutive cycles with no loss or duplication.
- Forwarding: pending 8'h7F→r4, rs_addr=4, rs_data=8'h00 → op_a=7F. With rt_addr=0 and a pending write to r0, op_b=rt_data and wb_wr_en=0.
- Flags/branch:
  - ALU SUB giving flags V=1,N=0,Z=0,C=1 with flags_en=1 → next cycle br_cond=LT gives br_taken=1, GE gives 0, CS gives 1.
  - A later op with flags_en=0 leaves flags_q unchanged.
- Counter wrap: with CW=4, retire 16 entries → retired returns to 0.
